irq_request_controller: RTL and testbench
=========================================

IRQ_REQUEST_CONTROLLER -- requirements
Module: irq_request_controller

Interface
REQ-001 Parameter N_SRC, default 8: number of interrupt source lines.
REQ-002 Parameter ID_W, default 3: width of irq_id, equal to clog2(N_SRC).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 irq_src  input  N_SRC  peripheral interrupt lines, synchronous to clk; rising edge = request.
REQ-006 mask_wr_en  input  1  write strobe for the enable mask.
REQ-007 mask_wr_data  input  N_SRC  new mask value; bit=1 enables that source.
REQ-008 return_from_isr  input  1  CPU end-of-ISR indication, one-cycle pulse.
REQ-009 interrupt_signal  output  1  one-cycle request pulse to the CPU interrupt control unit.
REQ-010 irq_id  output  ID_W  index of the source being serviced, read by the ISR.
REQ-011 irq_mask  output  N_SRC  current enable mask.
REQ-012 pending  output  N_SRC  latched pending requests.
REQ-013 overrun  output  1  one-cycle pulse when a request is lost.

Function
REQ-014 Rising-edge detect: src_q registers irq_src; edge[i] = irq_src[i] & ~src_q[i].
REQ-015 pending[i] sets on edge[i] regardless of mask, and clears only on service completion.
REQ-016 If set and clear of the same bit occur in one cycle, set wins.
REQ-017 eligible = pending & irq_mask; priority is fixed, lowest index highest.
REQ-018 FSM states: IDLE, SIGNAL, SERVICE.
REQ-019 IDLE: if eligible is nonzero, latch the winning index into irq_id and go to SIGNAL; otherwise stay.
REQ-020 SIGNAL: interrupt_signal=1 for exactly this one cycle, then go to SERVICE unconditionally.
REQ-021 SERVICE: interrupt_signal=0; on return_from_isr, clear pending[irq_id] and go to IDLE.
REQ-022 Nesting: no nesting; new requests only pend while in SIGNAL or SERVICE.
REQ-023 return_from_isr is ignored in IDLE and SIGNAL.
REQ-024 Latency: an edge sampled at edge t sets pending after t; FSM enters SIGNAL at t+1; interrupt_signal is high in cycle t+1..t+2 when unmasked and IDLE.
REQ-025 Back-to-back requests: after returning to IDLE, the next eligible source is signalled one cycle later (no cooldown).
REQ-026 Mask writes take effect the cycle after mask_wr_en.
REQ-027 Masking the in-service source does not abort SERVICE.
REQ-028 Masked pending sources are signalled once they are unmasked.
REQ-029 overrun pulses for one cycle when edge[i] arrives while pending[i]=1 and pending[i] is not being cleared that cycle.
REQ-030 irq_id holds its value from SIGNAL through SERVICE and is stable when return_from_isr arrives.
REQ-031 All outputs are registered; interrupt_signal is decoded from the registered state.

Reset
REQ-032 reset low forces immediately: state=IDLE, src_q=0, pending=0, irq_mask=0 (all disabled), irq_id=0, interrupt_signal=0, overrun=0.
REQ-033 Reset asserted mid-SERVICE abandons service; no pending bit survives.
REQ-034 After reset release, an irq_src line already high produces no request until it falls and rises again.

Structure
REQ-035 Package irq_ctrl_pkg holds the state enum, N_SRC, and ID_W defaults.
REQ-036 Sub-module irq_priority_encoder (eligible vector -> valid flag + lowest set index), purely combinational.

Verification
REQ-037 Mask=8'hFF; pulse irq_src[3] at edge 10 -> interrupt_signal high only in cycle 11-12, irq_id=3, pending=8'h08.
REQ-038 Raise irq_src[5] and irq_src[2] in the same cycle -> irq_id=2 first. return_from_isr -> pending=8'h20, then one IDLE cycle, then a second pulse with irq_id=5.
REQ-039 Mask=8'h00; pulse irq_src[1] -> no interrupt_signal and pending=8'h02. Write mask=8'h02 -> pulse within 2 cycles of the write, irq_id=1.
REQ-040 During SERVICE of id 4, give irq_src[4] a second rising edge -> overrun pulses once, pending[4] stays 1. return_from_isr in the same cycle as a new edge on 4 -> pending[4] remains 1 and is re-signalled.
REQ-041 Reset low mid-SERVICE with pending=8'h81 -> all outputs 0 asynchronously. After release with irq_src[0] held high -> no request.
REQ-042 return_from_isr pulsed while IDLE -> no state change, pending unchanged.

Source files
------------

// File: rtl/irq_ctrl_pkg.sv
// irq_ctrl_pkg: shared FSM state type and default sizing for the interrupt request controller.
package irq_ctrl_pkg;
    localparam int N_SRC_DEF = 8;
    localparam int ID_W_DEF  = $clog2(N_SRC_DEF);
    typedef enum logic [1:0] {ST_IDLE, ST_SIGNAL, ST_SERVICE} state_t;
endpackage

// File: rtl/irq_request_controller_if.sv
// irq_request_controller_if: peripheral/CPU-side signal bundle of the interrupt request controller.
interface irq_request_controller_if #(
    parameter int N_SRC = 8,
    parameter int ID_W  = 3
);
    logic [N_SRC-1:0] irq_src;
    logic             mask_wr_en;
    logic [N_SRC-1:0] mask_wr_data;
    logic             return_from_isr;
    logic             interrupt_signal;
    logic [ID_W-1:0]  irq_id;
    logic [N_SRC-1:0] irq_mask;
    logic [N_SRC-1:0] pending;
    logic             overrun;
    modport master (
        output irq_src, mask_wr_en, mask_wr_data, return_from_isr,
        input  interrupt_signal, irq_id, irq_mask, pending, overrun
    );
    modport slave (
        input  irq_src, mask_wr_en, mask_wr_data, return_from_isr,
        output interrupt_signal, irq_id, irq_mask, pending, overrun
    );
endinterface

// File: rtl/irq_request_controller_prio.sv
// irq_priority_encoder: combinational lowest-index-wins encoder with a valid flag.
module irq_priority_encoder
    import irq_ctrl_pkg::*;
#(
    parameter int N_SRC = N_SRC_DEF,
    parameter int ID_W  = ID_W_DEF
) (
    input  logic [N_SRC-1:0] i_eligible,
    output logic             o_valid,
    output logic [ID_W-1:0]  o_idx
);
    always_comb begin
        o_valid = |i_eligible;
        o_idx   = '0;
        for (int i = N_SRC - 1; i >= 0; i--)
            if (i_eligible[i]) o_idx = ID_W'(i);
    end
endmodule

// File: rtl/irq_request_controller.sv
// irq_request_controller: edge-detected, maskable, fixed-priority interrupt request FSM without nesting.
module irq_request_controller
    import irq_ctrl_pkg::*;
#(
    parameter int N_SRC = N_SRC_DEF,
    parameter int ID_W  = ID_W_DEF
) (
    input  logic clk,
    input  logic reset,
    irq_request_controller_if.slave bus
);
    state_t           r_state, w_next;
    logic             r_armed, r_overrun, w_valid, w_load;
    logic [N_SRC-1:0] r_src_q, r_pending, r_mask, w_edge, w_clr;
    logic [ID_W-1:0]  r_id, w_win;

    // r_armed suppresses the first sample after reset so lines already high are not seen as edges
    assign w_edge = r_armed ? (bus.irq_src & ~r_src_q) : '0;
    assign w_clr  = (r_state == ST_SERVICE && bus.return_from_isr) ? ({{(N_SRC-1){1'b0}}, 1'b1} << r_id) : '0;

    irq_priority_encoder #(.N_SRC(N_SRC), .ID_W(ID_W)) u_prio (
        .i_eligible (r_pending & r_mask),
        .o_valid    (w_valid),
        .o_idx      (w_win)
    );

    always_ff @(posedge clk or negedge reset)
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_next;

    always_comb begin
        w_load = (r_state == ST_IDLE) && w_valid;
        w_next = w_load ? ST_SIGNAL :
                 (r_state == ST_SIGNAL) ? ST_SERVICE :
                 (r_state == ST_SERVICE && bus.return_from_isr) ? ST_IDLE : r_state;
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            r_armed   <= 1'b0;
            r_src_q   <= '0;
            r_pending <= '0;
            r_mask    <= '0;
            r_id      <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_armed   <= 1'b1;
            r_src_q   <= bus.irq_src;
            r_pending <= (r_pending & ~w_clr) | w_edge;
            r_mask    <= bus.mask_wr_en ? bus.mask_wr_data : r_mask;
            r_overrun <= |(w_edge & r_pending & ~w_clr);
            if (w_load) r_id <= w_win;
        end

    assign bus.interrupt_signal = (r_state == ST_SIGNAL);
    assign bus.irq_id           = r_id;
    assign bus.irq_mask         = r_mask;
    assign bus.pending          = r_pending;
    assign bus.overrun          = r_overrun;
endmodule

// File: tb/tb_irq_request_controller.sv
// tb_irq_request_controller: directed stimulus with a queue-based scoreboard checking each interrupt pulse.
module tb_irq_request_controller;
    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    typedef struct {
        int         id;
        logic [7:0] pend;
        int         at;
    } exp_t;
    exp_t exp_q[$];

    irq_request_controller_if #(.N_SRC(8), .ID_W(3)) bus ();

    irq_request_controller #(.N_SRC(8), .ID_W(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_irq(input int id, input logic [7:0] pend, input int dly);
        exp_t e;
        e.id = id;
        e.pend = pend;
        e.at = cyc + dly;
        exp_q.push_back(e);
    endtask

    always @(negedge clk)
        if (bus.interrupt_signal === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_irq: got pulse id=%0d at cycle %0d, expected no pulse", bus.irq_id, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("irq_id", 32'(bus.irq_id), 32'(e.id));
                chk("irq_pending", 32'(bus.pending), 32'(e.pend));
                chk("irq_cycle", 32'(cyc), 32'(e.at));
            end
        end

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_irq"}, 32'(bus.interrupt_signal), 0);
        chk({tag, "_id"}, 32'(bus.irq_id), 0);
        chk({tag, "_mask"}, 32'(bus.irq_mask), 0);
        chk({tag, "_pending"}, 32'(bus.pending), 0);
        chk({tag, "_overrun"}, 32'(bus.overrun), 0);
    endtask

    task automatic isr_return();
        bus.return_from_isr = 1'b1;
        tick();
        bus.return_from_isr = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        bus.irq_src = '0;
        bus.mask_wr_en = 1'b0;
        bus.mask_wr_data = '0;
        bus.return_from_isr = 1'b0;
        tick(3);
        chk_zero_outputs("reset");
        reset = 1'b1;
        tick(2);

        bus.mask_wr_en = 1'b1;
        bus.mask_wr_data = 8'hFF;
        tick();
        bus.mask_wr_en = 1'b0;
        chk("mask_ff", 32'(bus.irq_mask), 32'h FF);

        // single source: pulse two cycles after the edge is driven
        bus.irq_src = 8'h08;
        expect_irq(3, 8'h08, 2);
        tick();
        bus.irq_src = '0;
        tick(2);
        chk("svc3_id", 32'(bus.irq_id), 3);
        chk("svc3_pending", 32'(bus.pending), 32'h08);
        isr_return();
        chk("svc3_cleared", 32'(bus.pending), 0);
        tick();

        // simultaneous 5 and 2: lowest index first, then 5 one IDLE cycle later
        bus.irq_src = 8'h24;
        expect_irq(2, 8'h24, 2);
        tick();
        bus.irq_src = '0;
        tick(2);
        expect_irq(5, 8'h20, 2);
        isr_return();
        chk("after2_pending", 32'(bus.pending), 32'h20);
        tick(2);
        chk("svc5_id", 32'(bus.irq_id), 5);
        isr_return();
        chk("after5_pending", 32'(bus.pending), 0);
        tick();

        // masked request pends, then fires once unmasked
        bus.mask_wr_en = 1'b1;
        bus.mask_wr_data = 8'h00;
        tick();
        bus.mask_wr_en = 1'b0;
        bus.irq_src = 8'h02;
        tick();
        bus.irq_src = '0;
        tick(3);
        chk("masked_pending", 32'(bus.pending), 32'h02);
        bus.mask_wr_en = 1'b1;
        bus.mask_wr_data = 8'h02;
        expect_irq(1, 8'h02, 2);
        tick();
        bus.mask_wr_en = 1'b0;
        tick(2);
        isr_return();
        chk("after1_pending", 32'(bus.pending), 0);
        bus.mask_wr_en = 1'b1;
        bus.mask_wr_data = 8'hFF;
        tick();
        bus.mask_wr_en = 1'b0;

        // overrun during service, then return coinciding with a new edge
        bus.irq_src = 8'h10;
        expect_irq(4, 8'h10, 2);
        tick();
        bus.irq_src = '0;
        tick(2);
        bus.irq_src = 8'h10;
        tick();
        bus.irq_src = '0;
        chk("overrun_hi", 32'(bus.overrun), 1);
        chk("overrun_pending", 32'(bus.pending), 32'h10);
        tick();
        chk("overrun_once", 32'(bus.overrun), 0);
        bus.irq_src = 8'h10;
        bus.return_from_isr = 1'b1;
        expect_irq(4, 8'h10, 2);
        tick();
        bus.irq_src = '0;
        bus.return_from_isr = 1'b0;
        chk("set_wins_pending", 32'(bus.pending), 32'h10);
        chk("set_wins_overrun", 32'(bus.overrun), 0);
        tick(2);
        isr_return();
        chk("after4_pending", 32'(bus.pending), 0);
        tick();

        // asynchronous reset in SERVICE with 0x81 pending
        bus.irq_src = 8'h81;
        expect_irq(0, 8'h81, 2);
        tick();
        bus.irq_src = '0;
        tick(2);
        chk("pre_reset_pending", 32'(bus.pending), 32'h81);
        #2 reset = 1'b0;
        #1 chk_zero_outputs("async");
        bus.irq_src = 8'h01;
        tick(2);
        reset = 1'b1;
        tick(4);
        chk("held_high_pending", 32'(bus.pending), 0);
        bus.irq_src = '0;
        tick();

        // return_from_isr in IDLE with a masked pending source
        bus.irq_src = 8'h40;
        tick();
        bus.irq_src = '0;
        tick();
        chk("idle_pending_before", 32'(bus.pending), 32'h40);
        isr_return();
        chk("idle_pending_after", 32'(bus.pending), 32'h40);
        chk("idle_no_irq", 32'(bus.interrupt_signal), 0);
        tick(3);

        chk("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
